// File: rtl/systolic_result_drain_if.sv
// Result stream from a column drain to its consumer: one word per
// valid/ready handshake, tagged with the row it came from.
interface systolic_result_drain_if #(
    parameter int DATA_W = 8,
    parameter int ROW_W  = 2
);
    logic [DATA_W-1:0] data;
    logic [ROW_W-1:0]  row;
    logic              valid;
    logic              ready;
    logic              last;

    modport master (output data, output row, output valid, output last, input ready);
    modport slave  (input data, input row, input valid, input last, output ready);
endinterface

// File: rtl/systolic_result_drain.sv
// Drains one PE column: holds drain_mode high for ROWS cycles so the
// c_out chain shifts results down into a local buffer (bottom row first),
// then streams the buffer out over a valid/ready interface.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_DRAIN | drain_mode high, capturing chain_in into mem[cnt]
// ST_SEND  | presenting mem[rd] until every word has been accepted
module systolic_result_drain #(
    parameter int ROWS   = 4,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [DATA_W-1:0]      chain_in_i,
    output logic                   drain_mode_o,
    output logic                   busy_o,
    output logic                   done_o,
    systolic_result_drain_if.master out_if
);
    localparam int ROW_W = $clog2(ROWS);
    localparam logic [ROW_W-1:0] LAST_IDX = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_SEND} state_t;

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  cnt_q, cnt_d;
    logic [ROW_W-1:0]  rd_q, rd_d;
    logic [ROW_W-1:0]  rd_nxt;
    logic [DATA_W-1:0] mem_q [ROWS];
    logic [DATA_W-1:0] mem_d [ROWS];
    logic              drain_q, drain_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ROW_W-1:0]  row_q, row_d;

    // State, counters, buffer and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            drain_q <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            row_q   <= '0;
            for (int i = 0; i < ROWS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            drain_q <= drain_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            data_q  <= data_d;
            row_q   <= row_d;
            mem_q   <= mem_d;
        end
    end

    // Next state and next registered outputs; outputs are computed one
    // cycle ahead so the first word is already presented on entry to SEND.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        mem_d   = mem_q;
        drain_d = drain_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        data_d  = data_q;
        row_d   = row_q;
        rd_nxt  = rd_q + ROW_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_DRAIN;
                    drain_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                mem_d[cnt_q] = chain_in_i;
                if (cnt_q == LAST_IDX) begin
                    // mem[0] was captured on an earlier edge since ROWS >= 2.
                    state_d = ST_SEND;
                    cnt_d   = '0;
                    drain_d = 1'b0;
                    rd_d    = '0;
                    valid_d = 1'b1;
                    data_d  = mem_q[0];
                    row_d   = LAST_IDX;
                    last_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + ROW_W'(1);
                end
            end
            ST_SEND: begin
                if (out_if.ready) begin
                    if (rd_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        rd_d    = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        rd_d   = rd_nxt;
                        data_d = mem_q[rd_nxt];
                        row_d  = LAST_IDX - rd_nxt;
                        last_d = (rd_nxt == LAST_IDX);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign drain_mode_o = drain_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign out_if.data  = data_q;
    assign out_if.row   = row_q;
    assign out_if.valid = valid_q;
    assign out_if.last  = last_q;

endmodule
